// File: rtl/sipo_deserializer_8bit_if.sv
// sipo_deserializer_8bit_if: serial input and parallel valid/ready output bundle for the deserializer
interface sipo_deserializer_8bit_if #(
  parameter int WIDTH = 8
);
  logic                     serial_in;
  logic                     shift_en;
  logic                     frame_sync;
  logic                     out_ready;
  logic                     clr_overrun;
  logic [WIDTH-1:0]         Q;
  logic                     out_valid;
  logic                     overrun;
  logic [$clog2(WIDTH)-1:0] bit_count;
  modport master (
    output serial_in, shift_en, frame_sync, out_ready, clr_overrun,
    input  Q, out_valid, overrun, bit_count
  );
  modport slave (
    input  serial_in, shift_en, frame_sync, out_ready, clr_overrun,
    output Q, out_valid, overrun, bit_count
  );
endinterface

// File: rtl/sipo_deserializer_8bit.sv
// sipo_deserializer_8bit: serial-to-parallel word assembler with one-entry valid/ready holding register
module sipo_deserializer_8bit #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                         clk,
  input logic                         reset,
  sipo_deserializer_8bit_if.slave     bus
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] seeded;
  logic             complete;
  logic             slot_free;
  // next shift value, frame-restart seed, and completion/slot decisions
  always_comb begin
    shifted   = MSB_FIRST ? {sr[WIDTH-2:0], bus.serial_in} : {bus.serial_in, sr[WIDTH-1:1]};
    seeded    = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bus.serial_in} : {bus.serial_in, {(WIDTH-1){1'b0}}};
    complete  = bus.shift_en && !bus.frame_sync && bus.bit_count == CW'(WIDTH - 1);
    slot_free = !bus.out_valid || bus.out_ready;
  end
  // assembly, holding register handshake and sticky overrun; a drop beats clr_overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      sr            <= '0;
      bus.bit_count <= '0;
      bus.Q         <= '0;
      bus.out_valid <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      if (bus.frame_sync) begin
        sr            <= bus.shift_en ? seeded : '0;
        bus.bit_count <= bus.shift_en ? CW'(1) : '0;
      end else if (bus.shift_en) begin
        sr            <= shifted;
        bus.bit_count <= complete ? '0 : bus.bit_count + 1'b1;
      end
      if (complete && slot_free) begin
        bus.Q         <= shifted;
        bus.out_valid <= 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      if (complete && !slot_free) bus.overrun <= 1'b1;
      else if (bus.clr_overrun) bus.overrun <= 1'b0;
    end
  end
endmodule
